// File: rtl/mlp_acc_requant_33s_18s.sv
// Neuron return path: accumulates LEN signed products onto a bias, rounds, saturates to OUT_WIDTH.
// Latency: last product accepted -> ROUND cycle -> out_valid in the following cycle (2 cycles).
// Backpressure: result held in HOLD until out_ready; prod_ready is low outside ACCUM.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, len, bias    begin a neuron (sampled in IDLE only); len/bias latched on start
//   prod_valid/prod     signed product stream; prod_ready high only while accumulating
//   out_valid/out_ready result handshake; dout = requantized result, sat = result clipped
//
// Build option: define MLP_ACC_RELU_EN to clamp negative rounded results to zero
// before saturation (the clamp does not set sat).
module mlp_acc_requant_33s_18s #(
  parameter int PROD_WIDTH = 33,
  parameter int OUT_WIDTH  = 18,
  parameter int ACC_WIDTH  = 42,
  parameter int FRAC_SHIFT = 8,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic [OUT_WIDTH-1:0]  bias,
  input  logic                  prod_valid,
  input  logic [PROD_WIDTH-1:0] prod,
  output logic                  prod_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  dout,
  output logic                  sat
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ROUND, S_HOLD} state_t;

  // Representable OUT range, expressed at accumulator width for the compare.
  localparam logic signed [ACC_WIDTH-1:0] R_MAX    = ACC_WIDTH'((64'd1 << (OUT_WIDTH-1)) - 64'd1);
  localparam logic signed [ACC_WIDTH-1:0] R_MIN    = ~R_MAX;
  localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(64'd1 << (FRAC_SHIFT-1));

  state_t                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]         dout_q, dout_d;
  logic                         sat_q, sat_d;

  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  rnd_sum;
  logic signed [ACC_WIDTH-1:0]  r_full;
  logic [OUT_WIDTH-1:0]         req_dout;
  logic                         req_sat;

  // Bias is Q.FRAC_SHIFT; products are Q.(2*FRAC_SHIFT), so the bias is aligned up.
  assign bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bias[OUT_WIDTH-1]}}, bias} <<< FRAC_SHIFT;
  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

  // Requantization: add half an output LSB then arithmetic shift (round half toward +inf).
  always_comb begin
    rnd_sum  = acc_q + RND_HALF;
    r_full   = rnd_sum >>> FRAC_SHIFT;
`ifdef MLP_ACC_RELU_EN
    if (r_full < 0) begin
      r_full = '0;
    end
`endif
    req_dout = r_full[OUT_WIDTH-1:0];
    req_sat  = 1'b0;
    if (r_full > R_MAX) begin
      req_dout = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      req_sat  = 1'b1;
    end else if (r_full < R_MIN) begin
      req_dout = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      req_sat  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = bias_ext;
          cnt_d   = len;
          state_d = (len == '0) ? S_ROUND : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (prod_valid) begin
          acc_d = acc_q + prod_ext;
          cnt_d = cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            state_d = S_ROUND;
          end
        end
      end
      S_ROUND: begin
        dout_d  = req_dout;
        sat_d   = req_sat;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      sat_q   <= sat_d;
    end
  end

  assign prod_ready = (state_q == S_ACCUM);
  assign out_valid  = (state_q == S_HOLD);
  assign dout       = dout_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_mlp_acc_requant_33s_18s.sv
// Directed bench for mlp_acc_requant_33s_18s: vector table plus backpressure and reset sequences.
// Latency: each transaction is stepped one clock at a time, outputs sampled 1 time unit after the edge.
// Backpressure: HOLD is stretched with out_ready low while start/prod_valid are pulsed.
module tb_mlp_acc_requant_33s_18s;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  len;
  logic [17:0] bias;
  logic        prod_valid;
  logic [32:0] prod;
  logic        prod_ready;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] dout;
  logic        sat;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [17:0] bias;
    logic [9:0]  len;
    logic [32:0] p0;
    logic [32:0] p1;
    logic        gap;
    logic [17:0] exp_dout;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[11];

  mlp_acc_requant_33s_18s dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .bias       (bias),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dout       (dout),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full neuron: start, feed products, check ROUND timing, result, handshake.
  task automatic run_vec(input vec_t v);
    logic [17:0] exp_d;
    logic        exp_s;
    exp_d = v.exp_dout;
    exp_s = v.exp_sat;
`ifdef MLP_ACC_RELU_EN
    if (exp_d[17]) begin
      exp_d = '0;
      exp_s = 1'b0;
    end
`endif
    chk({v.name, " idle_prod_ready"}, prod_ready, 0);
    start = 1'b1;
    len   = v.len;
    bias  = v.bias;
    step();
    start = 1'b0;
    if (v.len != 0) begin
      chk({v.name, " accum_prod_ready"}, prod_ready, 1);
      prod_valid = 1'b1;
      prod       = v.p0;
      step();
      if (v.len == 2) begin
        if (v.gap) begin
          prod_valid = 1'b0;
          step();
          chk({v.name, " gap_prod_ready"}, prod_ready, 1);
          prod_valid = 1'b1;
        end
        prod = v.p1;
        step();
      end
      prod_valid = 1'b0;
    end
    chk({v.name, " round_out_valid"}, out_valid, 0);
    chk({v.name, " round_prod_ready"}, prod_ready, 0);
    step();
    chk({v.name, " hold_out_valid"}, out_valid, 1);
    chk({v.name, " dout"}, dout, exp_d);
    chk({v.name, " sat"}, sat, exp_s);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({v.name, " after_hs_out_valid"}, out_valid, 0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    len        = '0;
    bias       = '0;
    prod_valid = 1'b0;
    prod       = '0;
    out_ready  = 1'b0;

    //           name        bias       len  p0                 p1              gap   exp_dout   sat
    vecs[0]  = '{"basic",    18'h00100, 2,  33'h0_0001_0000,   33'h0_0000_8000, 1'b0, 18'h00280, 1'b0};
    vecs[1]  = '{"rnd_p80",  18'h00000, 1,  33'h0_0000_0080,   33'h0,           1'b0, 18'h00001, 1'b0};
    vecs[2]  = '{"rnd_m80",  18'h00000, 1,  -33'sd128,         33'h0,           1'b0, 18'h00000, 1'b0};
    vecs[3]  = '{"rnd_m81",  18'h00000, 1,  -33'sd129,         33'h0,           1'b0, 18'h3FFFF, 1'b0};
    vecs[4]  = '{"sat_pos",  18'h00000, 1,  33'h0_FFFF_FFFF,   33'h0,           1'b0, 18'h1FFFF, 1'b1};
    vecs[5]  = '{"sat_neg",  18'h00000, 1,  33'h1_0000_0000,   33'h0,           1'b0, 18'h20000, 1'b1};
    vecs[6]  = '{"len0",     18'h3FF00, 0,  33'h0,             33'h0,           1'b0, 18'h3FF00, 1'b0};
    vecs[7]  = '{"max_edge", 18'h1FFFF, 1,  33'h0_0000_007F,   33'h0,           1'b0, 18'h1FFFF, 1'b0};
    vecs[8]  = '{"max_over", 18'h1FFFF, 1,  33'h0_0000_0080,   33'h0,           1'b0, 18'h1FFFF, 1'b1};
    vecs[9]  = '{"min_edge", 18'h20000, 1,  -33'sd128,         33'h0,           1'b0, 18'h20000, 1'b0};
    vecs[10] = '{"min_over", 18'h20000, 1,  -33'sd129,         33'h0,           1'b0, 18'h20000, 1'b1};

    step();
    step();
    chk("reset prod_ready", prod_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset dout", dout, 0);
    chk("reset sat", sat, 0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Mixed signs with an idle cycle between products: -0x10000 + 0x20000 - 0x100 -> 0xFF.
    run_vec('{"mixed_gap", 18'h3FF00, 2, 33'h0_0002_0000, -33'sd256, 1'b1, 18'h000FF, 1'b0});

    // Backpressure: 0x10000 + 0x100 -> 0x101, held while start/prod_valid are pulsed.
    start = 1'b1;
    len   = 10'd1;
    bias  = 18'h00100;
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 33'h0_0000_0100;
    step();
    prod_valid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp out_valid", out_valid, 1);
      chk("bp dout", dout, 18'h00101);
      chk("bp sat", sat, 0);
      chk("bp prod_ready", prod_ready, 0);
      start      = k[0];
      len        = 10'd0;
      bias       = 18'h3FF00;
      prod_valid = 1'b1;
      prod       = 33'h0_7FFF_FFFF;
      step();
    end
    start      = 1'b0;
    prod_valid = 1'b0;
    chk("bp final dout", dout, 18'h00101);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp released out_valid", out_valid, 0);
    chk("bp idle prod_ready", prod_ready, 0);
    // Product offered in IDLE must be dropped.
    prod_valid = 1'b1;
    prod       = 33'h0_0000_1000;
    step();
    prod_valid = 1'b0;
    chk("idle drop prod_ready", prod_ready, 0);
    run_vec('{"after_drop", 18'h00000, 1, 33'h0_0000_0100, 33'h0, 1'b0, 18'h00001, 1'b0});

    // Reset in the middle of a len=3 accumulation.
    start = 1'b1;
    len   = 10'd3;
    bias  = 18'h00100;
    step();
    start      = 1'b0;
    prod_valid = 1'b1;
    prod       = 33'h0_0000_1000;
    step();
    prod_valid = 1'b0;
    start      = 1'b1;
    len        = 10'd0;
    step();
    start = 1'b0;
    chk("start ignored in accum", prod_ready, 1);
    reset = 1'b1;
    #2;
    chk("midrst prod_ready", prod_ready, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst dout", dout, 0);
    chk("midrst sat", sat, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post rst out_valid", out_valid, 0);
      chk("post rst prod_ready", prod_ready, 0);
    end
    run_vec('{"after_rst", 18'h00000, 1, 33'h0_0000_0100, 33'h0, 1'b0, 18'h00001, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
